// File: rtl/serial_adder_defs.sv
// Shared definitions for the bit-serial adder: controller state encoding and default word width.
package serial_adder_defs;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder built from two half adders; the two partial carries are
// mutually exclusive, so a plain OR merges them.
module full_adder_1b (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(x),  .b(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Existing half-adder primitive: one XOR for the sum, one AND for the carry.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB first over
// WIDTH cycles, then publishes {COUT,S} with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_defs::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             COUT
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  full_adder_1b u_fa (
    .x (sh_a[0]),
    .y (sh_b[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      COUT  <= 1'b0;
    end else if (load) begin
      sh_a  <= A;
      sh_b  <= B;
      acc   <= '0;
      carry <= CIN;
      cnt   <= '0;
    end else if (step) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      acc   <= {fa_s, acc[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      // The final sum bit lands in the MSB on the same edge the result is published.
      if (last) begin
        S    <= {fa_s, acc[WIDTH-1:1]};
        COUT <= fa_co;
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule
